// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory stage.
package lsu_pkg;

  // Access sequencer states: wait for an op, hold the request, one-cycle completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Default number of REQ cycles tolerated without mem_ready before aborting.
  localparam logic [7:0] TIMEOUT_DEFAULT = 8'd255;

  // 16-bit words on a byte-addressed bus: any odd address is misaligned.
  function automatic logic is_misaligned(input logic addr_lsb);
    return addr_lsb;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Request/ready bus between the load/store stage and the data memory.
interface lsu_mem_stage_if #(
  parameter int n = 16
);
  logic         mem_req;
  logic         mem_we;
  logic [n-1:0] mem_addr;
  logic [n-1:0] mem_wdata;
  logic         mem_ready;
  logic [n-1:0] mem_rdata;

  // The load/store stage issues requests.
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  // The memory answers them.
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu_timeout_ctr.sv
// Counts consecutive REQ cycles without mem_ready; flags the cycle that reaches the limit.
module lsu_timeout_ctr #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Clear wins over enable so a completing access always restarts from zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 8'd0;
    end else if (en) begin
      count_d = count_q + 8'd1;
    end
  end

  // Expired on the waiting cycle whose increment would reach the limit.
  always_comb begin
    expired = en && (count_q == (LIMIT - 8'd1));
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store stage: turns memread/memwrite into a req/ready memory access and stalls the datapath meanwhile.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int         n       = 16,
  parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [n-1:0]     addr,
  input  logic [n-1:0]     wdata,
  output logic [n-1:0]     readdata,
  output logic             stall,
  output logic             fault,
  lsu_mem_stage_if.master  mem
);

  lsu_state_t   state_q, state_d;
  logic [n-1:0] readdata_q, readdata_d;
  logic         fault_q, fault_d;
  logic         mem_we_q, mem_we_d;
  logic [n-1:0] mem_addr_q, mem_addr_d;
  logic [n-1:0] mem_wdata_q, mem_wdata_d;

  logic op;
  logic misaligned;
  logic in_req;
  logic ctr_expired;

  assign op         = memread | memwrite;
  assign misaligned = is_misaligned(addr[0]);
  assign in_req     = (state_q == REQ);

  // Wait-cycle counter: runs only while a request is outstanding and unanswered.
  lsu_timeout_ctr #(
    .LIMIT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .clr     (!in_req || mem.mem_ready),
    .en      (in_req && !mem.mem_ready),
    .expired (ctr_expired)
  );

  // State and captured-value registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      readdata_q  <= '0;
      fault_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      readdata_q  <= readdata_d;
      fault_q     <= fault_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next state plus the values latched on launch, completion, misalignment and timeout.
  always_comb begin
    state_d     = state_q;
    readdata_d  = readdata_q;
    fault_d     = fault_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (op) begin
          // Read and write together proceeds as a write but is still an error.
          if (memread && memwrite) begin
            fault_d = 1'b1;
          end
          if (misaligned) begin
            fault_d    = 1'b1;
            readdata_d = '0;
            state_d    = DONE;
          end else begin
            mem_addr_d  = addr;
            mem_wdata_d = wdata;
            mem_we_d    = memwrite;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (mem.mem_ready) begin
          if (!mem_we_q) begin
            readdata_d = mem.mem_rdata;
          end
          state_d = DONE;
        end else if (ctr_expired) begin
          fault_d    = 1'b1;
          readdata_d = '0;
          state_d    = DONE;
        end
      end
      // DONE never looks at the inputs, so a held op cannot relaunch.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: stall covers the launch cycle and every REQ cycle; request fields come from registers.
  always_comb begin
    stall         = ((state_q == IDLE) && op) || in_req;
    readdata      = readdata_q;
    fault         = fault_q;
    mem.mem_req   = in_req;
    mem.mem_we    = mem_we_q;
    mem.mem_addr  = mem_addr_q;
    mem.mem_wdata = mem_wdata_q;
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] readdata;
  logic        stall;
  logic        fault;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_n;
  int req_n;

  lsu_mem_stage_if #(.n(16)) mbus ();

  lsu_mem_stage #(.n(16), .TIMEOUT(8'd255)) dut (
    .clk      (clk),
    .reset    (reset),
    .memread  (memread),
    .memwrite (memwrite),
    .addr     (addr),
    .wdata    (wdata),
    .readdata (readdata),
    .stall    (stall),
    .fault    (fault),
    .mem      (mbus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op and run until stall drops (the DONE cycle). mem_ready rises on the
  // REQ cycle numbered ready_after (0 = first), or never if negative. Request fields are
  // checked against the launch values while the inputs are deliberately disturbed.
  task automatic do_op(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                       input int ready_after, input string tag,
                       output int s_n, output int r_n);
    logic stable;
    logic finished;
    memread  = rd;
    memwrite = wr;
    addr     = a;
    wdata    = d;
    s_n      = 0;
    r_n      = 0;
    stable   = 1'b1;
    finished = 1'b0;
    for (int c = 0; c < 400; c++) begin
      mbus.mem_ready = mbus.mem_req && (ready_after >= 0) && (r_n >= ready_after);
      #1;
      if (!stall) begin
        finished = 1'b1;
        break;
      end
      s_n++;
      if (mbus.mem_req) begin
        r_n++;
        if (mbus.mem_addr !== a || mbus.mem_wdata !== d || mbus.mem_we !== wr) stable = 1'b0;
        addr  = a ^ 16'hFF00;
        wdata = ~d;
      end
      tick();
    end
    mbus.mem_ready = 1'b0;
    check({tag, "_done_reached"}, {31'd0, finished}, 32'd1);
    check({tag, "_req_fields_stable"}, {31'd0, stable}, 32'd1);
  endtask

  initial begin
    reset          = 1'b0;
    memread        = 1'b0;
    memwrite       = 1'b0;
    addr           = 16'h0;
    wdata          = 16'h0;
    mbus.mem_ready = 1'b0;
    mbus.mem_rdata = 16'h0;

    // Reset for two cycles
    tick();
    tick();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_req", {31'd0, mbus.mem_req}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_readdata", {16'd0, readdata}, 32'h0);
    check("rst_mem_addr", {16'd0, mbus.mem_addr}, 32'h0);
    check("rst_mem_we", {31'd0, mbus.mem_we}, 32'd0);
    reset = 1'b1;

    // Load, memory ready on first REQ cycle
    mbus.mem_rdata = 16'hBEEF;
    do_op(1'b1, 1'b0, 16'h0010, 16'h0000, 0, "load", stall_n, req_n);
    check("load_stall_cycles", stall_n, 2);
    check("load_req_cycles", req_n, 1);
    check("load_readdata", {16'd0, readdata}, 32'hBEEF);
    check("load_mem_addr", {16'd0, mbus.mem_addr}, 32'h0010);
    check("load_mem_we", {31'd0, mbus.mem_we}, 32'd0);
    $display("load  addr=0010 stall=%0d req=%0d readdata=%h", stall_n, req_n, readdata);
    tick();
    check("load_no_relaunch", {31'd0, mbus.mem_req}, 32'd0);
    memread = 1'b0;

    // Store with five wait states
    tick();
    mbus.mem_rdata = 16'hDEAD;
    do_op(1'b0, 1'b1, 16'h0020, 16'h1234, 5, "store", stall_n, req_n);
    check("store_stall_cycles", stall_n, 7);
    check("store_req_cycles", req_n, 6);
    check("store_fault", {31'd0, fault}, 32'd0);
    check("store_readdata_kept", {16'd0, readdata}, 32'hBEEF);
    check("store_mem_wdata", {16'd0, mbus.mem_wdata}, 32'h1234);
    $display("store addr=0020 stall=%0d req=%0d fault=%0d", stall_n, req_n, fault);
    tick();
    memwrite = 1'b0;

    // Timeout: memory never answers
    tick();
    do_op(1'b1, 1'b0, 16'h0040, 16'h0000, -1, "timeout", stall_n, req_n);
    check("timeout_req_cycles", req_n, 255);
    check("timeout_stall_cycles", stall_n, 256);
    check("timeout_fault", {31'd0, fault}, 32'd1);
    check("timeout_readdata", {16'd0, readdata}, 32'h0);
    $display("timeout addr=0040 stall=%0d req=%0d fault=%0d", stall_n, req_n, fault);
    tick();
    memread = 1'b0;

    // Next op after a timeout still works
    tick();
    mbus.mem_rdata = 16'h5A5A;
    do_op(1'b1, 1'b0, 16'h0042, 16'h0000, 1, "post_to", stall_n, req_n);
    check("post_to_stall_cycles", stall_n, 3);
    check("post_to_readdata", {16'd0, readdata}, 32'h5A5A);
    check("post_to_fault_sticky", {31'd0, fault}, 32'd1);
    $display("load  addr=0042 stall=%0d req=%0d readdata=%h", stall_n, req_n, readdata);
    tick();
    memread = 1'b0;

    // Plain reset clears the sticky fault
    reset = 1'b0;
    tick();
    check("rst2_fault", {31'd0, fault}, 32'd0);
    check("rst2_readdata", {16'd0, readdata}, 32'h0);
    reset = 1'b1;

    // Misaligned load: no memory access
    tick();
    do_op(1'b1, 1'b0, 16'h0011, 16'h0000, 0, "misal", stall_n, req_n);
    check("misal_req_cycles", req_n, 0);
    check("misal_stall_cycles", stall_n, 1);
    check("misal_fault", {31'd0, fault}, 32'd1);
    check("misal_readdata", {16'd0, readdata}, 32'h0);
    $display("misal addr=0011 stall=%0d req=%0d fault=%0d", stall_n, req_n, fault);
    tick();
    memread = 1'b0;

    // Back-to-back: load then store on the very next instruction
    tick();
    mbus.mem_rdata = 16'hCAFE;
    do_op(1'b1, 1'b0, 16'h0100, 16'h0000, 0, "b2b_load", stall_n, req_n);
    check("b2b_load_readdata", {16'd0, readdata}, 32'hCAFE);
    check("b2b_load_req_cycles", req_n, 1);
    tick();
    check("b2b_gap_no_relaunch", {31'd0, mbus.mem_req}, 32'd0);
    do_op(1'b0, 1'b1, 16'h0102, 16'hA55A, 2, "b2b_store", stall_n, req_n);
    check("b2b_store_req_cycles", req_n, 3);
    check("b2b_store_stall_cycles", stall_n, 4);
    check("b2b_store_readdata_kept", {16'd0, readdata}, 32'hCAFE);
    check("b2b_fault_sticky", {31'd0, fault}, 32'd1);
    $display("b2b   load+store stall=%0d req=%0d readdata=%h", stall_n, req_n, readdata);
    tick();
    memwrite = 1'b0;

    // Read and write together: performed as a write, flagged as fault
    reset = 1'b0;
    tick();
    reset = 1'b1;
    do_op(1'b1, 1'b1, 16'h0200, 16'h7777, 0, "rdwr", stall_n, req_n);
    check("rdwr_mem_we", {31'd0, mbus.mem_we}, 32'd1);
    check("rdwr_fault", {31'd0, fault}, 32'd1);
    check("rdwr_readdata_kept", {16'd0, readdata}, 32'h0);
    $display("rdwr  addr=0200 stall=%0d req=%0d fault=%0d", stall_n, req_n, fault);
    tick();
    memread  = 1'b0;
    memwrite = 1'b0;

    // Load to get nonzero readdata, then reset in the middle of a REQ
    tick();
    mbus.mem_rdata = 16'h1111;
    do_op(1'b1, 1'b0, 16'h0300, 16'h0000, 0, "pre_mid", stall_n, req_n);
    check("pre_mid_readdata", {16'd0, readdata}, 32'h1111);
    tick();
    memread        = 1'b0;
    tick();
    memread        = 1'b1;
    addr           = 16'h0060;
    mbus.mem_ready = 1'b0;
    tick();
    tick();
    check("mid_in_req", {31'd0, mbus.mem_req}, 32'd1);
    reset = 1'b0;
    tick();
    check("mid_rst_req", {31'd0, mbus.mem_req}, 32'd0);
    check("mid_rst_fault", {31'd0, fault}, 32'd0);
    check("mid_rst_readdata", {16'd0, readdata}, 32'h0);
    memread = 1'b0;
    reset   = 1'b1;
    #1;
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    tick();
    check("mid_rst_idle", {31'd0, mbus.mem_req}, 32'd0);
    $display("midrst req=%0d fault=%0d readdata=%h", mbus.mem_req, fault, readdata);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
